// File: rtl/alu_exec_sequencer.sv
// Multi-cycle add/sub/mul/div execute sequencer with valid/ready on both sides.
// Multiply is shift-add (LSB first); divide is restoring (MSB first), one bit per cycle.
module alu_exec_sequencer #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [1:0]        opcode,
  input  logic [DATA_W-1:0] operand1,
  input  logic [DATA_W-1:0] operand2,
  output logic [DATA_W-1:0] result,
  output logic              result_valid,
  input  logic              result_ready,
  output logic              div_by_zero,
  output logic              busy
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DECODE = 2'd1,
    S_EXEC   = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [1:0]        r_op, w_op_nxt;
  // r_a: multiplicand (mul) or dividend shifting into quotient (div)
  // r_b: multiplier (mul) or divisor (div); r_acc: product or partial remainder
  logic [DATA_W-1:0] r_a, w_a_nxt;
  logic [DATA_W-1:0] r_b, w_b_nxt;
  logic [DATA_W-1:0] r_acc, w_acc_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic              r_dz, w_dz_nxt;
  logic [DATA_W-1:0] r_result, w_result_nxt;
  logic              r_dbz, w_dbz_nxt;

  logic [DATA_W-1:0] w_mul_acc;
  logic [DATA_W:0]   w_trial;
  logic              w_div_fits;
  logic [DATA_W:0]   w_div_diff;
  logic [DATA_W-1:0] w_div_rem;
  logic [DATA_W-1:0] w_div_quo;
  logic [DATA_W-1:0] w_calc;

  // One shift-add / restoring-divide step computed from the current registers
  assign w_mul_acc  = r_b[0] ? (r_acc + r_a) : r_acc;
  assign w_trial    = {r_acc, r_a[DATA_W-1]};
  assign w_div_fits = (w_trial >= {1'b0, r_b});
  assign w_div_diff = w_trial - {1'b0, r_b};
  assign w_div_rem  = w_div_fits ? w_div_diff[DATA_W-1:0] : w_trial[DATA_W-1:0];
  assign w_div_quo  = {r_a[DATA_W-2:0], w_div_fits};

  assign instr_ready  = (r_state == S_IDLE);
  assign busy         = (r_state != S_IDLE);
  assign result_valid = (r_state == S_DONE);
  assign result       = r_result;
  assign div_by_zero  = r_dbz;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_op     <= 2'b00;
      r_a      <= '0;
      r_b      <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_dz     <= 1'b0;
      r_result <= '0;
      r_dbz    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_op     <= w_op_nxt;
      r_a      <= w_a_nxt;
      r_b      <= w_b_nxt;
      r_acc    <= w_acc_nxt;
      r_cnt    <= w_cnt_nxt;
      r_dz     <= w_dz_nxt;
      r_result <= w_result_nxt;
      r_dbz    <= w_dbz_nxt;
    end
  end

  // Next-state and datapath update
  always_comb begin
    w_state_nxt  = r_state;
    w_op_nxt     = r_op;
    w_a_nxt      = r_a;
    w_b_nxt      = r_b;
    w_acc_nxt    = r_acc;
    w_cnt_nxt    = r_cnt;
    w_dz_nxt     = r_dz;
    w_result_nxt = r_result;
    w_dbz_nxt    = r_dbz;
    w_calc       = '0;

    case (r_state)
      S_IDLE: begin
        if (instr_valid) begin
          w_op_nxt    = opcode;
          w_a_nxt     = operand1;
          w_b_nxt     = operand2;
          w_acc_nxt   = '0;
          w_dz_nxt    = 1'b0;
          w_state_nxt = S_DECODE;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end

      S_DECODE: begin
        // Divide-by-zero takes one EXEC pass so its result lands after edge T+2
        if ((r_op == OP_MUL) || ((r_op == OP_DIV) && (r_b != '0))) begin
          w_cnt_nxt = CNT_W'(DATA_W);
        end else begin
          w_cnt_nxt = CNT_W'(1);
        end
        w_dz_nxt    = (r_op == OP_DIV) && (r_b == '0);
        w_state_nxt = S_EXEC;
      end

      S_EXEC: begin
        w_cnt_nxt = r_cnt - CNT_W'(1);
        case (r_op)
          OP_ADD: w_calc = r_a + r_b;
          OP_SUB: w_calc = r_a - r_b;
          OP_MUL: begin
            w_acc_nxt = w_mul_acc;
            w_a_nxt   = {r_a[DATA_W-2:0], 1'b0};
            w_b_nxt   = {1'b0, r_b[DATA_W-1:1]};
            w_calc    = w_mul_acc;
          end
          OP_DIV: begin
            if (r_dz) begin
              w_calc = '1;
            end else begin
              w_acc_nxt = w_div_rem;
              w_a_nxt   = w_div_quo;
              w_calc    = w_div_quo;
            end
          end
          default: w_calc = '0;
        endcase
        if (r_cnt == CNT_W'(1)) begin
          w_result_nxt = w_calc;
          w_dbz_nxt    = r_dz;
          w_state_nxt  = S_DONE;
        end else begin
          w_state_nxt = S_EXEC;
        end
      end

      S_DONE: begin
        if (result_ready) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_DONE;
        end
      end

      default: w_state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_alu_exec_sequencer.sv
// Scoreboard bench for alu_exec_sequencer: expected results are queued at issue
// and compared (value, flag, latency, handshake) when the sequencer presents them.
module tb_alu_exec_sequencer;

  logic       clk;
  logic       reset;
  logic       instr_valid;
  logic       instr_ready;
  logic [1:0] opcode;
  logic [7:0] operand1;
  logic [7:0] operand2;
  logic [7:0] result;
  logic       result_valid;
  logic       result_ready;
  logic       div_by_zero;
  logic       busy;

  int n_checks;
  int n_errs;
  int n_issued;
  int n_accepts;

  typedef struct packed {
    logic [7:0] res;
    logic       dbz;
    logic [7:0] lat;
  } exp_t;

  exp_t sb_q[$];

  alu_exec_sequencer #(.DATA_W(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .opcode       (opcode),
    .operand1     (operand1),
    .operand2     (operand2),
    .result       (result),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .div_by_zero  (div_by_zero),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!reset && instr_valid && instr_ready) n_accepts <= n_accepts + 1;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    logic [15:0] p;
    p = {8'h00, a} * {8'h00, b};
    e.dbz = 1'b0;
    e.lat = 8'd2;
    case (op)
      2'b00: e.res = a + b;
      2'b01: e.res = a - b;
      2'b10: begin e.res = p[7:0]; e.lat = 8'd9; end
      default: begin
        if (b == 8'h00) begin
          e.res = 8'hFF;
          e.dbz = 1'b1;
        end else begin
          e.res = a / b;
          e.lat = 8'd9;
        end
      end
    endcase
    return e;
  endfunction

  // Called at a negedge with the sequencer idle; returns at a negedge, idle again.
  task automatic issue(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                       input int bp, input bit keep_valid);
    exp_t e;
    int k;
    int busy_cnt;
    sb_q.push_back(model(op, a, b));
    chk("idle_ready", instr_ready, 1);
    instr_valid  = 1'b1;
    opcode       = op;
    operand1     = a;
    operand2     = b;
    result_ready = (bp == 0);
    n_issued++;
    @(posedge clk);
    @(negedge clk);
    if (!keep_valid) instr_valid = 1'b0;
    k = 0;
    busy_cnt = 0;
    while (1) begin
      if (busy) busy_cnt++;
      if (result_valid || k >= 40) break;
      if (instr_ready) chk("no_accept_busy", instr_ready, 0);
      @(posedge clk);
      @(negedge clk);
      k++;
    end
    e = sb_q.pop_front();
    if (!result_valid) begin
      chk("timeout", 0, 1);
      instr_valid  = 1'b0;
      result_ready = 1'b1;
      return;
    end
    chk("latency", k, e.lat);
    chk("result", result, e.res);
    chk("dbz", div_by_zero, e.dbz);
    chk("ready_in_done", instr_ready, 0);
    instr_valid = 1'b0;
    for (int i = 0; i < bp; i++) begin
      chk("bp_valid", result_valid, 1);
      chk("bp_result", result, e.res);
      chk("bp_dbz", div_by_zero, e.dbz);
      @(posedge clk);
      @(negedge clk);
      if (busy) busy_cnt++;
    end
    result_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("busy_cycles", busy_cnt, e.lat + 1 + bp);
    chk("post_valid", result_valid, 0);
    chk("post_ready", instr_ready, 1);
    chk("post_busy", busy, 0);
    chk("held_result", result, e.res);
    chk("held_dbz", div_by_zero, e.dbz);
  endtask

  initial begin
    n_checks = 0; n_errs = 0; n_issued = 0; n_accepts = 0;
    reset = 1'b1; instr_valid = 1'b0; opcode = 2'b00;
    operand1 = 8'h00; operand2 = 8'h00; result_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_result", result, 0);
    chk("rst_valid", result_valid, 0);
    chk("rst_dbz", div_by_zero, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", instr_ready, 1);
    reset = 1'b0;

    issue(2'b00, 8'h7F, 8'h01, 0, 1'b0);
    issue(2'b00, 8'hFF, 8'h02, 0, 1'b0);
    issue(2'b01, 8'h05, 8'h07, 0, 1'b1);
    issue(2'b10, 8'h10, 8'h11, 0, 1'b0);
    issue(2'b10, 8'd12, 8'd11, 0, 1'b0);
    issue(2'b11, 8'd200, 8'd7, 0, 1'b0);
    issue(2'b11, 8'd5, 8'd9, 0, 1'b0);
    issue(2'b11, 8'hFF, 8'h01, 0, 1'b0);
    issue(2'b11, 8'h2A, 8'h00, 5, 1'b0);
    issue(2'b00, 8'h01, 8'h01, 0, 1'b0);
    for (int r = 0; r < 8; r++) begin
      issue(2'($urandom_range(3, 0)), 8'($urandom), 8'($urandom), $urandom_range(2, 0), 1'b0);
    end
    issue(2'b10, 8'hF3, 8'h5D, 1, 1'b0);

    // Abort a multiply partway through EXEC
    instr_valid = 1'b1; opcode = 2'b10; operand1 = 8'h37; operand2 = 8'h29;
    n_issued++;
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    repeat (4) begin @(posedge clk); @(negedge clk); end
    chk("mid_mul_busy", busy, 1);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("abort_result", result, 0);
    chk("abort_valid", result_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_ready", instr_ready, 1);
    chk("abort_dbz", div_by_zero, 0);
    issue(2'b00, 8'h03, 8'h04, 0, 1'b0);

    @(posedge clk);
    @(negedge clk);
    chk("accept_count", n_accepts, n_issued);
    chk("sb_empty", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
